mem_writeback_stage: RTL and testbench

//  Back end of the two-stage pipeline: consumes the execute/memory pipeline register outputs.

---
 rtl/mem_writeback_stage.sv | 161 ++++++++++++++++
 tb/tb_mem_writeback_stage.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mem_writeback_stage.sv
// Memory/writeback back end: issues data-memory loads/stores over req/ack, selects the
// register-file writeback value and stalls upstream while an access is outstanding.
module mem_writeback_stage #(
   parameter int         DBITS       = 32,
   parameter int         IDX_BITS    = 4,
   parameter int         MEM_TIMEOUT = 255,
   parameter logic [1:0] SEL_ALU     = 2'd0,
   parameter logic [1:0] SEL_MEM     = 2'd1,
   parameter logic [1:0] SEL_PC      = 2'd2,
   parameter logic [1:0] SEL_SYS     = 2'd3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [IDX_BITS-1:0] inWrtIndex,
   input  logic                inRegWrEn,
   input  logic [1:0]          inMulSel,
   input  logic [DBITS-1:0]    inAluOut,
   input  logic [DBITS-1:0]    inData2Out,
   input  logic [DBITS-1:0]    inPC,
   input  logic [DBITS-1:0]    inSysDataOut,
   input  logic                inIsLoad,
   input  logic                inIsStore,
   output logic                memReq,
   output logic                memWe,
   output logic [DBITS-1:0]    memAddr,
   output logic [DBITS-1:0]    memWdata,
   input  logic                memAck,
   input  logic [DBITS-1:0]    memRdata,
   output logic                memStall,
   output logic                memErr,
   output logic                wbWrEn,
   output logic [IDX_BITS-1:0] wbIndex,
   output logic [DBITS-1:0]    wbData,
   output logic                fwdValid,
   output logic [IDX_BITS-1:0] fwdIndex,
   output logic [DBITS-1:0]    fwdData
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

   localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

   state_t                r_state, w_next;
   logic [7:0]            r_cnt;
   logic                  r_ld, r_rwe;
   logic [IDX_BITS-1:0]   r_idx;
   logic                  r_memReq, r_memWe, r_memErr, r_wbWrEn;
   logic [DBITS-1:0]      r_memAddr, r_memWdata, r_wbData;
   logic [IDX_BITS-1:0]   r_wbIndex;

   logic                  w_memOp, w_aligned, w_timeout;
   logic [DBITS-1:0]      w_wbSel;

   assign w_memOp   = inIsLoad | inIsStore;
   assign w_aligned = (inAluOut[1:0] == 2'b00);
   assign w_timeout = (r_cnt == TO_LAST);

   always_comb begin
      w_wbSel = '0;
      case (inMulSel)
         SEL_ALU: w_wbSel = inAluOut;
         SEL_MEM: w_wbSel = '0;   // load data never comes through this path
         SEL_PC:  w_wbSel = inPC;
         SEL_SYS: w_wbSel = inSysDataOut;
         default: w_wbSel = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_memOp && w_aligned) w_next = S_REQ;
         S_REQ:   if (memAck || w_timeout) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt      <= '0;
         r_ld       <= 1'b0;
         r_rwe      <= 1'b0;
         r_idx      <= '0;
         r_memReq   <= 1'b0;
         r_memWe    <= 1'b0;
         r_memAddr  <= '0;
         r_memWdata <= '0;
         r_memErr   <= 1'b0;
         r_wbWrEn   <= 1'b0;
         r_wbIndex  <= '0;
         r_wbData   <= '0;
      end else begin
         r_memErr <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!w_memOp) begin
                  r_wbWrEn  <= inRegWrEn;
                  r_wbIndex <= inWrtIndex;
                  r_wbData  <= w_wbSel;
               end else if (!w_aligned) begin
                  // back-to-back misaligned ops must not stretch the pulse
                  r_memErr <= ~r_memErr;
                  r_wbWrEn <= 1'b0;
               end else begin
                  r_memReq   <= 1'b1;
                  r_memWe    <= inIsStore;
                  r_memAddr  <= inAluOut;
                  r_memWdata <= inData2Out;
                  r_ld       <= inIsLoad & ~inIsStore;
                  r_rwe      <= inRegWrEn;
                  r_idx      <= inWrtIndex;
                  r_cnt      <= '0;
                  r_wbWrEn   <= 1'b0;
               end
            end
            S_REQ: begin
               if (memAck) begin
                  r_memReq <= 1'b0;
                  if (r_ld) begin
                     r_wbWrEn  <= r_rwe;
                     r_wbIndex <= r_idx;
                     r_wbData  <= memRdata;
                  end else begin
                     r_wbWrEn <= 1'b0;
                  end
               end else if (w_timeout) begin
                  r_memReq <= 1'b0;
                  r_memErr <= 1'b1;
                  r_wbWrEn <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: r_wbWrEn <= 1'b0;
         endcase
      end
   end

   always_comb begin
      memStall = ((r_state == S_IDLE) && w_memOp && w_aligned) || (r_state == S_REQ);
      fwdValid = r_wbWrEn;
      fwdIndex = r_wbIndex;
      fwdData  = r_wbData;
   end

   assign memReq   = r_memReq;
   assign memWe    = r_memWe;
   assign memAddr  = r_memAddr;
   assign memWdata = r_memWdata;
   assign memErr   = r_memErr;
   assign wbWrEn   = r_wbWrEn;
   assign wbIndex  = r_wbIndex;
   assign wbData   = r_wbData;

endmodule

// File: tb/tb_mem_writeback_stage.sv
// Directed and randomized bench for mem_writeback_stage against a transaction-level model.
module tb_mem_writeback_stage;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  inWrtIndex = '0;
   logic        inRegWrEn = 1'b0;
   logic [1:0]  inMulSel = '0;
   logic [31:0] inAluOut = '0, inData2Out = '0, inPC = '0, inSysDataOut = '0;
   logic        inIsLoad = 1'b0, inIsStore = 1'b0;
   logic        memReq, memWe, memAck = 1'b0, memStall, memErr, wbWrEn, fwdValid;
   logic [31:0] memAddr, memWdata, memRdata = '0, wbData, fwdData;
   logic [3:0]  wbIndex, fwdIndex;

   int checks = 0;
   int failures = 0;

   mem_writeback_stage #(.DBITS(32), .IDX_BITS(4), .MEM_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .inWrtIndex(inWrtIndex), .inRegWrEn(inRegWrEn),
      .inMulSel(inMulSel), .inAluOut(inAluOut), .inData2Out(inData2Out), .inPC(inPC),
      .inSysDataOut(inSysDataOut), .inIsLoad(inIsLoad), .inIsStore(inIsStore),
      .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
      .memAck(memAck), .memRdata(memRdata), .memStall(memStall), .memErr(memErr),
      .wbWrEn(wbWrEn), .wbIndex(wbIndex), .wbData(wbData),
      .fwdValid(fwdValid), .fwdIndex(fwdIndex), .fwdData(fwdData));

   always #5 clk = ~clk;

   // Reference: an outstanding access is a pending transaction with an age in cycles.
   bit          m_known = 0, m_pending = 0, m_retire = 0, m_isld = 0, m_rwe = 0, m_rst = 0;
   int          m_age = 0;
   logic [3:0]  m_idx = '0;
   logic        e_req = 0, e_we = 0, e_err = 0, e_wb = 0;
   logic [31:0] e_addr = '0, e_wdata = '0, e_wbd = '0;
   logic [3:0]  e_wbi = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] sel_val();
      case (inMulSel)
         2'd0:    return inAluOut;
         2'd2:    return inPC;
         2'd3:    return inSysDataOut;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_edge();
      bit memop = inIsLoad | inIsStore;
      bit misal = (inAluOut[1:0] != 2'b00);
      if (reset) begin
         m_pending = 0; m_retire = 0; m_age = 0; m_isld = 0; m_rwe = 0; m_idx = '0;
         e_req = 0; e_we = 0; e_err = 0; e_wb = 0;
         e_addr = '0; e_wdata = '0; e_wbd = '0; e_wbi = '0;
      end else if (m_retire) begin
         m_retire = 0; e_wb = 0; e_err = 0;
      end else if (m_pending) begin
         e_err = 0;
         if (memAck) begin
            m_pending = 0; m_retire = 1; e_req = 0;
            e_wb = m_isld & m_rwe;
            if (m_isld) begin e_wbi = m_idx; e_wbd = memRdata; end
         end else if (m_age + 1 == TO) begin
            m_pending = 0; m_retire = 1; e_req = 0; e_err = 1; e_wb = 0;
         end else begin
            m_age++;
         end
      end else if (!memop) begin
         e_err = 0; e_wb = inRegWrEn; e_wbi = inWrtIndex; e_wbd = sel_val();
      end else if (misal) begin
         e_err = !e_err; e_wb = 0;
      end else begin
         m_pending = 1; m_age = 0; e_req = 1; e_we = inIsStore;
         e_addr = inAluOut; e_wdata = inData2Out;
         m_isld = inIsLoad & !inIsStore; m_rwe = inRegWrEn; m_idx = inWrtIndex;
         e_err = 0; e_wb = 0;
      end
      m_rst = reset;
   endtask

   // One clock: check combinational outputs, advance model, check registered outputs.
   task automatic tick(input logic ack, input logic [31:0] rdata);
      bit exp_stall;
      memAck = ack; memRdata = rdata;
      #1;
      if (m_known && !reset) begin
         exp_stall = m_pending || (!m_retire && (inIsLoad | inIsStore) && inAluOut[1:0] == 2'b00);
         chk("memStall", memStall, exp_stall);
      end
      model_edge();
      @(posedge clk);
      #1;
      m_known = 1;
      chk("memReq", memReq, e_req);
      chk("memErr", memErr, e_err);
      chk("wbWrEn", wbWrEn, e_wb);
      chk("fwdValid", fwdValid, e_wb);
      if (e_req || m_rst) begin
         chk("memWe", memWe, e_we);
         chk("memAddr", memAddr, e_addr);
         chk("memWdata", memWdata, e_wdata);
      end
      if (e_wb || m_rst) begin
         chk("wbIndex", wbIndex, e_wbi);
         chk("wbData", wbData, e_wbd);
         chk("fwdIndex", fwdIndex, e_wbi);
         chk("fwdData", fwdData, e_wbd);
      end
   endtask

   task automatic present(input bit ld, input bit st, input bit rwe, input logic [3:0] idx,
                          input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] d2);
      inIsLoad = ld; inIsStore = st; inRegWrEn = rwe; inWrtIndex = idx;
      inMulSel = sel; inAluOut = alu; inData2Out = d2;
      inPC = 32'h0000_1004; inSysDataOut = 32'h5555_AAAA;
   endtask

   initial begin
      reset = 1; tick(0, 0); tick(0, 0); reset = 0;
      // ALU op and other selects
      present(0, 0, 1, 4'd5, 2'd0, 32'h1234, 0); tick(0, 0);
      present(0, 0, 1, 4'd6, 2'd2, 32'h9, 0);    tick(0, 0);
      present(0, 0, 1, 4'd7, 2'd3, 32'h9, 0);    tick(0, 0);
      present(0, 0, 1, 4'd8, 2'd1, 32'h9, 0);    tick(0, 0);
      // load, ack on the third REQ cycle, held through DONE
      present(1, 0, 1, 4'd3, 2'd1, 32'h100, 0);
      tick(0, 0); tick(0, 0); tick(0, 0); tick(1, 32'hDEADBEEF); tick(0, 0);
      // store with immediate ack, held through DONE
      present(0, 1, 1, 4'd9, 2'd0, 32'h40, 32'hCAFE);
      tick(0, 0); tick(1, 32'h1111); tick(0, 0);
      // load+store together acts as store
      present(1, 1, 1, 4'd2, 2'd1, 32'h80, 32'h77);
      tick(0, 0); tick(1, 32'h2222); tick(0, 0);
      // misaligned, twice in a row, then once more
      present(1, 0, 1, 4'd3, 2'd1, 32'h102, 0); tick(0, 0); tick(0, 0); tick(0, 0);
      present(0, 0, 0, 4'd1, 2'd0, 32'h3, 0);   tick(0, 0);
      // timeout
      present(1, 0, 1, 4'd4, 2'd1, 32'h200, 0);
      for (int i = 0; i < TO + 2; i++) tick(0, 0);
      // reset mid-REQ, stray ack, then a normal ALU op
      present(1, 0, 1, 4'd4, 2'd1, 32'h300, 0); tick(0, 0); tick(0, 0);
      reset = 1; tick(0, 0); reset = 0;
      present(0, 0, 0, 4'd0, 2'd0, 32'h0, 0); tick(1, 32'hBAD0BAD0);
      present(0, 0, 1, 4'd11, 2'd0, 32'hABCD, 0); tick(0, 0); tick(0, 0);
      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         present(($urandom % 4) == 0, ($urandom % 5) == 0, $urandom % 2, 4'($urandom),
                 2'($urandom), (($urandom % 4) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC),
                 $urandom);
         inPC = $urandom; inSysDataOut = $urandom;
         reset = (($urandom % 97) == 0);
         tick(($urandom % 3) == 0, $urandom);
      end
      reset = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
